pcore_arb: RTL

PCORE_ARB -- requirements
Module: pcore_arb

---
 rtl/pcore_arb_if.sv | 39 +++
 rtl/pcore_arb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pcore_arb_if.sv
// Requester, response and external-core signal bundle for pcore_arb.
// The arbiter connects through the slave modport; the environment
// (requesters plus the unrolled core) drives through the master modport.
interface pcore_arb_if;
  logic          req0_vld;
  logic          req1_vld;
  logic          req0_rdy;
  logic          req1_rdy;
  logic          req0_d;
  logic          req1_d;
  logic [0:63]   req0_inp;
  logic [0:63]   req1_inp;
  logic [0:127]  req0_key;
  logic [0:127]  req1_key;
  logic          rsp0_vld;
  logic          rsp1_vld;
  logic          rsp0_rdy;
  logic          rsp1_rdy;
  logic [0:63]   rsp_out;
  logic          core_d;
  logic [0:63]   core_inp;
  logic [0:127]  core_key;
  logic [0:63]   core_out;
  logic          busy;

  modport slave (
    input  req0_vld, req1_vld, req0_d, req1_d, req0_inp, req1_inp,
           req0_key, req1_key, rsp0_rdy, rsp1_rdy, core_out,
    output req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_out,
           core_d, core_inp, core_key, busy
  );

  modport master (
    output req0_vld, req1_vld, req0_d, req1_d, req0_inp, req1_inp,
           req0_key, req1_key, rsp0_rdy, rsp1_rdy, core_out,
    input  req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_out,
           core_d, core_inp, core_key, busy
  );
endinterface

// File: rtl/pcore_arb.sv
// Two-requester round-robin front end for an external combinational
// (unrolled) block-cipher core. One job is in flight at a time: the
// granted request is latched into the core operand registers, the core
// is given WAIT_CYC cycles to settle, and its result is captured and
// held on rsp_out until the owning requester takes it.
module pcore_arb #(
  parameter int unsigned WAIT_CYC = 2  // settle cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  pcore_arb_if.slave  bus
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;     // requester that completed most recently
  logic          id_q, id_d;         // owner of the job in flight
  logic          core_d_q, core_d_d;
  logic [0:63]   core_inp_q, core_inp_d;
  logic [0:127]  core_key_q, core_key_d;
  logic [0:63]   rsp_out_q, rsp_out_d;

  logic          gnt_vld_s;
  logic          gnt_id_s;
  logic          accept_s;
  logic          rsp_rdy_s;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (bus.req0_vld && bus.req1_vld) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = ~last_q;
    end else if (bus.req0_vld) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b0;
    end else if (bus.req1_vld) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b1;
    end else begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  // A job is taken only from IDLE, so the core operands stay frozen
  // for the whole multicycle settle and response window.
  assign accept_s  = (state_q == ST_IDLE) && gnt_vld_s;
  assign rsp_rdy_s = id_q ? bus.rsp1_rdy : bus.rsp0_rdy;

  // Next-state and datapath load decisions for the job FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    id_d       = id_q;
    core_d_d   = core_d_q;
    core_inp_d = core_inp_q;
    core_key_d = core_key_q;
    rsp_out_d  = rsp_out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          id_d  = gnt_id_s;
          cnt_d = WAIT_LD;
          if (gnt_id_s) begin
            core_d_d   = bus.req1_d;
            core_inp_d = bus.req1_inp;
            core_key_d = bus.req1_key;
          end else begin
            core_d_d   = bus.req0_d;
            core_inp_d = bus.req0_inp;
            core_key_d = bus.req0_key;
          end
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // <= also catches a zero count so the FSM can never stall here
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          rsp_out_d = bus.core_out;
          state_d   = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_rdy_s) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      core_d_q   <= 1'b0;
      core_inp_q <= 64'd0;
      core_key_q <= 128'd0;
      rsp_out_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      id_q       <= id_d;
      core_d_q   <= core_d_d;
      core_inp_q <= core_inp_d;
      core_key_q <= core_key_d;
      rsp_out_q  <= rsp_out_d;
    end
  end

  // Ready is withheld during reset even if a requester is already valid.
  assign bus.req0_rdy = accept_s && !gnt_id_s && !rst;
  assign bus.req1_rdy = accept_s &&  gnt_id_s && !rst;
  assign bus.rsp0_vld = (state_q == ST_RESP) && !id_q;
  assign bus.rsp1_vld = (state_q == ST_RESP) &&  id_q;
  assign bus.rsp_out  = rsp_out_q;
  assign bus.core_d   = core_d_q;
  assign bus.core_inp = core_inp_q;
  assign bus.core_key = core_key_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
